// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: column-multiplexed driver for a 5x7 LED matrix.
// Frames enter a shadow buffer through a valid/ready handshake and are
// promoted to the displayed buffer only at a frame boundary. Each column is
// lit for DWELL cycles after a BLANK-cycle gap with every column off.
module matrix_scan_driver #(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned BLANK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [34:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic        ch1,
  input  logic        ch0,
  output logic [4:0]  linha_out,
  output logic [6:0]  acender_coluna,
  output logic        frame_sync
);

  localparam int unsigned MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic {
    S_BLANK,
    S_SCAN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      col_q, col_d;
  logic [1:0]      mode_q, mode_d;
  logic [34:0]     active_q, active_d;
  logic [34:0]     shadow_q, shadow_d;
  logic            full_q, full_d;
  logic [4:0]      row_q, row_d;
  logic [6:0]      an_q, an_d;
  logic            sync_q, sync_d;

  logic            boundary;
  logic [1:0]      mode_next;
  logic [4:0]      col_data;

  // Row bits of column c: pixel (r, c) lives at bit r*7+c.
  function automatic logic [4:0] col_bits(input logic [34:0] f, input logic [2:0] c);
    col_bits = '0;
    for (int unsigned r = 0; r < 5; r++) begin
      col_bits[r] = f[r*7 + int'(c)];
    end
  endfunction

  assign mode_next = {ch1, ch0};
  assign col_data  = col_bits(active_q, col_q);

  // Next-state for scan timing, column outputs and the frame double buffer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    mode_d   = mode_q;
    active_d = active_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    row_d    = row_q;
    an_d     = an_q;
    sync_d   = 1'b0;
    boundary = 1'b0;

    case (state_q)
      S_BLANK: begin
        row_d = '0;
        an_d  = '1;
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          mode_d  = mode_next;
          // Column outputs for the dwell use the mode sampled on this edge.
          case (mode_next)
            2'b00: begin
              an_d  = 7'h7F ^ (7'd1 << col_q);
              row_d = col_data;
            end
            2'b01: begin
              an_d  = 7'h7F ^ (7'd1 << col_q);
              row_d = ~col_data;
            end
            2'b10: begin
              an_d  = '1;
              row_d = '0;
            end
            default: begin
              an_d  = 7'h7F ^ (7'd1 << col_q);
              row_d = '1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          row_d   = '0;
          an_d    = '1;
          if (col_q == 3'd6) begin
            col_d    = '0;
            sync_d   = 1'b1;
            boundary = 1'b1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase

    // Promotion and acceptance are exclusive: a load needs ~full, promotion needs full.
    if (boundary && full_q) begin
      active_d = shadow_q;
      full_d   = 1'b0;
    end else if (frame_valid && !full_q) begin
      shadow_d = frame_in;
      full_d   = 1'b1;
    end
  end

  // State and registered outputs; reset blanks the panel and drops any pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BLANK;
      cnt_q    <= '0;
      col_q    <= '0;
      mode_q   <= '0;
      active_q <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      row_q    <= '0;
      an_q     <= '1;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      row_q    <= row_d;
      an_q     <= an_d;
      sync_q   <= sync_d;
    end
  end

  assign frame_ready    = ~full_q;
  assign linha_out      = row_q;
  assign acender_coluna = an_q;
  assign frame_sync     = sync_q;

endmodule
